// File: rtl/cache_port_arbiter_if.sv
// Bundles the demand, prefetch and cache-side signals of the shared cache read port.
// Handshake: a requester holds req (and stable addresses) until its one-cycle ready
// pulse, when data is valid; the cache accepts a cycle with cache_data_req_o=1 and
// wait_cache=0, and later returns data with a one-cycle cache_data_ready pulse.
interface cache_port_arbiter_if;
  logic             dm_req;
  logic [1:0][31:0] dm_r_addr;
  logic             dm_ready;
  logic [1:0][31:0] dm_data;
  logic             pf_req;
  logic [1:0][31:0] pf_r_addr;
  logic             pf_cancel;
  logic             pf_ready;
  logic [1:0][31:0] pf_data;
  logic             cache_data_req_o;
  logic [1:0][31:0] cache_r_addr_o;
  logic             wait_cache;
  logic             cache_data_ready;
  logic [1:0][31:0] cache_data_i;

  // Arbiter side.
  modport master (
    input  dm_req, dm_r_addr, pf_req, pf_r_addr, pf_cancel,
    input  wait_cache, cache_data_ready, cache_data_i,
    output dm_ready, dm_data, pf_ready, pf_data, cache_data_req_o, cache_r_addr_o
  );

  // Requester/cache environment side.
  modport slave (
    output dm_req, dm_r_addr, pf_req, pf_r_addr, pf_cancel,
    output wait_cache, cache_data_ready, cache_data_i,
    input  dm_ready, dm_data, pf_ready, pf_data, cache_data_req_o, cache_r_addr_o
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// Shares one cache read port between a demand requester and the prefetch engine.
// One transaction at a time; demand has fixed priority, and a starvation counter
// forces a prefetch grant after STARVE_LIMIT consecutive demand grants.
module cache_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  cache_port_arbiter_if.master bus,
  output logic                 busy,
  output logic [1:0]           dbg_state,
  output logic [3:0]           dbg_starve_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2,
    RESP      = 2'd3
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;      // 0 = demand, 1 = prefetch
  logic             drop_q, drop_d;        // prefetch cancelled while its data is in flight
  logic [3:0]       starve_q, starve_d;
  logic [1:0][31:0] addr_q, addr_d;
  logic [1:0][31:0] data_q, data_d;
  logic [1:0][31:0] dm_data_q, dm_data_d;
  logic [1:0][31:0] pf_data_q, pf_data_d;
  logic             cache_req_q, cache_req_d;
  logic             dm_ready_q, dm_ready_d;
  logic             pf_ready_q, pf_ready_d;
  logic             pf_kill;

  // A cancel only matters while the prefetch engine owns the port.
  assign pf_kill = owner_q & bus.pf_cancel;

  // Next-state, arbitration and output-register computation.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    starve_d    = starve_q;
    addr_d      = addr_q;
    data_d      = data_q;
    dm_data_d   = dm_data_q;
    pf_data_d   = pf_data_q;
    cache_req_d = 1'b0;
    dm_ready_d  = 1'b0;
    pf_ready_d  = 1'b0;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (bus.pf_req && (starve_q == LIMIT)) begin
          owner_d     = 1'b1;
          addr_d      = bus.pf_r_addr;
          starve_d    = 4'd0;
          cache_req_d = 1'b1;
          state_d     = ISSUE;
        end else if (bus.dm_req) begin
          owner_d     = 1'b0;
          addr_d      = bus.dm_r_addr;
          cache_req_d = 1'b1;
          state_d     = ISSUE;
          if (!bus.pf_req)             starve_d = 4'd0;
          else if (starve_q < LIMIT)   starve_d = starve_q + 4'd1;
          else                         starve_d = LIMIT;
        end else if (bus.pf_req) begin
          owner_d     = 1'b1;
          addr_d      = bus.pf_r_addr;
          starve_d    = 4'd0;
          cache_req_d = 1'b1;
          state_d     = ISSUE;
        end else begin
          starve_d = 4'd0;
        end
      end
      ISSUE: begin
        if (bus.wait_cache) begin
          // Not yet accepted: a cancel can still withdraw the request entirely.
          if (pf_kill) state_d = IDLE;
          else         cache_req_d = 1'b1;
        end else begin
          // Accepted this cycle; a simultaneous cancel must still drain the response.
          state_d = WAIT_DATA;
          if (pf_kill) drop_d = 1'b1;
        end
      end
      WAIT_DATA: begin
        if (pf_kill) drop_d = 1'b1;
        if (bus.cache_data_ready) begin
          data_d = bus.cache_data_i;
          if (drop_q || pf_kill) begin
            drop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = RESP;
            if (owner_q) begin
              pf_data_d  = bus.cache_data_i;
              pf_ready_d = 1'b1;
            end else begin
              dm_data_d  = bus.cache_data_i;
              dm_ready_d = 1'b1;
            end
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      drop_q      <= 1'b0;
      starve_q    <= 4'd0;
      addr_q      <= '0;
      data_q      <= '0;
      dm_data_q   <= '0;
      pf_data_q   <= '0;
      cache_req_q <= 1'b0;
      dm_ready_q  <= 1'b0;
      pf_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      starve_q    <= starve_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      dm_data_q   <= dm_data_d;
      pf_data_q   <= pf_data_d;
      cache_req_q <= cache_req_d;
      dm_ready_q  <= dm_ready_d;
      pf_ready_q  <= pf_ready_d;
    end
  end

  assign bus.cache_data_req_o = cache_req_q;
  assign bus.cache_r_addr_o   = addr_q;
  assign bus.dm_ready         = dm_ready_q;
  assign bus.dm_data          = dm_data_q;
  // A cancel landing in the response cycle suppresses the prefetch pulse.
  assign bus.pf_ready         = pf_ready_q & ~bus.pf_cancel;
  assign bus.pf_data          = pf_data_q;
  assign busy                 = (state_q != IDLE);
  assign dbg_state            = state_q;
  assign dbg_starve_cnt       = starve_q;

endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Shares the prefetcher cache read port (`cache_data_req` plus two 32-bit read addresses, two 32-bit data words, and the `wait_cache`/`cache_data_ready` handshake) between two requesters: a demand requester (`dm_*`) and the prefetch engine (`pf_*`). It accepts one transaction at a time and runs it to completion against the cache. Demand has fixed priority; a starvation counter guarantees the prefetch engine forward progress. The block sits between the prefetcher top level and the cache.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive demand grants allowed while a prefetch request waits; range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- dm_req  in  1  demand request, level; held until dm_ready
- dm_r_addr  in  2x32  demand addresses [1:0]; stable while dm_req is high
- dm_ready  out  1  one-cycle pulse; dm_data valid this cycle
- dm_data  out  2x32  returned words [1:0]
- pf_req  in  1  prefetch request, level; held until pf_ready or pf_cancel
- pf_r_addr  in  2x32  prefetch addresses [1:0]
- pf_cancel  in  1  one-cycle pulse; abandon the current or pending prefetch
- pf_ready  out  1  one-cycle pulse; pf_data valid this cycle
- pf_data  out  2x32  returned words [1:0]
- cache_data_req_o  out  1  request to cache
- cache_r_addr_o  out  2x32  addresses to cache
- wait_cache  in  1  cache stall; request not accepted while high
- cache_data_ready  in  1  one-cycle pulse; cache_data_i valid
- cache_data_i  in  2x32  cache read data
- busy  out  1  high in any state other than IDLE

## Operation
States: IDLE, ISSUE, WAIT_DATA, RESP.

- **IDLE:** arbitrate among the requests present this cycle.
  - If `pf_req` is high and `starve_cnt == STARVE_LIMIT`: grant prefetch.
  - Else if `dm_req` is high: grant demand.
  - Else if `pf_req` is high: grant prefetch.
  - With no request, stay in IDLE.
  - On a grant, latch the owner (`owner`: 0 = demand, 1 = prefetch) and both addresses into `addr_q`, then go to ISSUE.
- **starve_cnt** (4 bits):
  - Increments on a demand grant while `pf_req` is high, saturating at STARVE_LIMIT.
  - Clears to 0 on any prefetch grant.
  - Clears to 0 in any IDLE cycle where `pf_req` is low.
- **ISSUE:**
  - `cache_data_req_o = 1`, `cache_r_addr_o = addr_q`.
  - Accepted on a cycle with `wait_cache = 0`, then go to WAIT_DATA.
  - While `wait_cache = 1`, hold the request and addresses unchanged.
- **WAIT_DATA:**
  - `cache_data_req_o = 0`.
  - On `cache_data_ready = 1`, capture `cache_data_i` into `data_q` and go to RESP.
  - `cache_data_ready` is ignored in every other state.
- **RESP:**
  - Pulse `owner ? pf_ready : dm_ready` for exactly one cycle, with `data_q` on the owner's data bus.
  - Go to IDLE next cycle.
- **Data buses:** `dm_data`/`pf_data` hold their last value (0 after reset) outside RESP.
- **pf_cancel:**
  - Owner is prefetch in ISSUE before acceptance: drop the request, return to IDLE next cycle, no cache transaction.
  - Owner is prefetch in WAIT_DATA: set `drop_q`. The cache transaction still completes. On `cache_data_ready`, return to IDLE with no `pf_ready` pulse.
  - Owner is prefetch in RESP: the pulse is suppressed.
  - In IDLE, or with demand as owner: no effect.
  - `drop_q` clears on return to IDLE.
- **Requester contract:** a requester deasserting `req` before its ready pulse is illegal, except prefetch via `pf_cancel`. The arbiter does not re-sample `req` after the grant.
- **Reset (asynchronous, any state):**
  - State IDLE; all outputs 0.
  - `starve_cnt`, `owner`, `drop_q`, `addr_q` and `data_q` all 0.
  - An in-flight cache response arriving after reset is ignored because the block is in IDLE.

## Timing
- Request high in IDLE at cycle N: `cache_data_req_o` is high at N+1.
- With `wait_cache` low, acceptance happens at N+1 and WAIT_DATA starts at N+2.
- `cache_data_ready` at cycle M: the ready pulse is at M+1, and IDLE at M+2.
- Minimum request-to-ready latency is 3 cycles, for a `cache_data_ready` at N+2.
- Back-to-back throughput: one transaction per (cache latency + 3) cycles. The earliest next grant is in the IDLE cycle M+2.
- Outputs are registered or state-decoded with no combinational path from the `req` inputs. `cache_r_addr_o` comes from `addr_q` only.

## Test plan
- **Single demand:** `dm_req` with addresses 0x100/0x104, cache returns 0xAAAA0001/0xAAAA0002 two cycles after acceptance. Expect `cache_data_req_o` one cycle after the request, then a 1-cycle `dm_ready` with `dm_data` equal to those values. `pf_ready` stays 0.
- **Simultaneous requests, STARVE_LIMIT=4:**
  - `dm_req` and `pf_req` held continuously for 6 transactions: grant order D, D, D, D, P, D.
  - `starve_cnt` reads 4 before the prefetch grant and 0 after it.
- **Cache stall:** `wait_cache` high for 5 cycles during ISSUE. `cache_data_req_o` and the addresses stay constant for 6 cycles. Exactly one acceptance occurs, and data returns correctly.
- **Cancel:**
  - (a) `pf_cancel` during ISSUE with `wait_cache` high: back to IDLE, no acceptance.
  - (b) `pf_cancel` during WAIT_DATA: the `cache_data_ready` is consumed, no `pf_ready` pulse, and a pending `dm_req` is granted in the following IDLE cycle.
- **Reset mid-transaction:** assert `reset` low in WAIT_DATA. All outputs go to 0 immediately. A `cache_data_ready` after release produces no ready pulse. A new `dm_req` completes normally.
- **Idle stability:** no requests for 20 cycles. `busy`, `cache_data_req_o` and both ready outputs stay 0, and `starve_cnt` stays 0.
